// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared register bank constants and types for the read arbiter
package regbank_pkg;
    localparam int REG_AW    = 4;
    localparam int REG_DW    = 32;
    localparam int REG_COUNT = 16;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/regbank_read_arbiter_if.sv
// rtl/regbank_read_arbiter_if.sv - request, bank-port and response bundle for regbank_read_arbiter
interface regbank_read_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 4,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [AW-1:0]      rd_sel;
    logic [DW-1:0]      rd_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic [NREQ-1:0]    rsp_ready;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;

    modport master (
        output req_valid, req_addr, rsp_ready, rd_data, wr_en, wr_addr, wr_data,
        input  req_ready, rd_sel, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, rd_data, wr_en, wr_addr, wr_data,
        output req_ready, rd_sel, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first request at or above ptr, modulo NREQ
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);
    always_comb begin
        int p;
        grant = '0;
        idx   = '0;
        p     = 0;
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int k = NREQ - 1; k >= 0; k--) begin
            p = int'(ptr) + k;
            if (p >= NREQ) p = p - NREQ;
            if (req[p]) begin
                grant    = '0;
                grant[p] = 1'b1;
                idx      = IW'(p);
            end
        end
    end
endmodule

// File: rtl/regbank_read_arbiter.sv
// rtl/regbank_read_arbiter.sv - round-robin sharing of the register bank read port; REGBANK_BYPASS_EN adds same-cycle write forwarding
module regbank_read_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input logic                  clk,
    input logic                  reset,
    regbank_read_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [AW-1:0]   sel_q;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   cap_data;
    logic [NREQ-1:0] rsp_valid_q;
    logic [DW-1:0]   rsp_data_q;
    logic            accept;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    // A grant is always an accept: req_ready is only raised where req_valid is set.
    assign accept        = (state == IDLE) && !reset && (|gnt);
    assign gnt_addr      = bus.req_addr[int'(gnt_idx)*AW +: AW];
    assign bus.req_ready = accept ? gnt : '0;
    assign bus.rd_sel    = accept ? gnt_addr : sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

`ifdef REGBANK_BYPASS_EN
    assign cap_data = (bus.wr_en && (bus.wr_addr == gnt_addr)) ? bus.wr_data : bus.rd_data;
`else
    logic unused_wr;
    assign unused_wr = ^{bus.wr_en, bus.wr_addr, bus.wr_data};
    assign cap_data  = bus.rd_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            sel_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_data_q  <= cap_data;
                        rsp_valid_q <= gnt;
                        rr_ptr      <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                        sel_q       <= gnt_addr;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // Ready on a requester with nothing pending is masked off here.
                    if (|(bus.rsp_ready & rsp_valid_q)) begin
                        rsp_valid_q <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regbank_read_arbiter.sv
// tb/tb_regbank_read_arbiter.sv - randomized and directed checks of regbank_read_arbiter against a queue/array reference model
module tb_regbank_read_arbiter;
    import regbank_pkg::*;

    localparam int NREQ = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regbank_read_arbiter_if #(.NREQ(NREQ), .AW(4), .DW(32)) bus ();

    regbank_read_arbiter #(.NREQ(NREQ), .AW(4), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] bank [16];
    assign bus.rd_data = bank[bus.rd_sel];

    int checks = 0;
    int failures = 0;
    int m_pend = -1;
    int m_ptr = 0;
    logic [31:0] m_data = '0;
    int cyc = 0;
    int glog[$];
    int gcyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] addr_of(input int i);
        logic [NREQ*4-1:0] a;
        a = bus.req_addr;
        return a[i*4 +: 4];
    endfunction

    function automatic int exp_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock of model-checked operation; inputs must already be driven.
    task automatic step();
        int g;
        logic [31:0] cap;
        logic [NREQ-1:0] rr;
        g = -1;
        cap = '0;
        #1;
        rr = bus.rsp_ready;
        if (m_pend < 0) begin
            g = exp_grant();
            chk("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
            if (g >= 0) begin
                chk("rd_sel", 32'(bus.rd_sel), 32'(addr_of(g)));
                cap = bank[addr_of(g)];
`ifdef REGBANK_BYPASS_EN
                if (bus.wr_en && bus.wr_addr == addr_of(g)) cap = bus.wr_data;
`endif
            end
        end else begin
            chk("req_ready_hold", 32'(bus.req_ready), 32'd0);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << m_pend);
            chk("rsp_data", bus.rsp_data, m_data);
        end
        @(posedge clk);
        #1;
        if (bus.wr_en) bank[bus.wr_addr] = bus.wr_data;
        cyc++;
        if (m_pend < 0 && g >= 0) begin
            m_pend = g;
            m_data = cap;
            m_ptr  = (g + 1) % NREQ;
            glog.push_back(g);
            gcyc.push_back(cyc);
        end else if (m_pend >= 0 && rr[m_pend]) begin
            m_pend = -1;
        end
        chk("rr_ptr", 32'(dut.rr_ptr), 32'(m_ptr));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_pend = -1;
        m_ptr = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive(input logic [2:0] v, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [2:0] rdy);
        bus.req_valid = v;
        bus.req_addr  = {a2, a1, a0};
        bus.rsp_ready = rdy;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = 32'h1000_0000 + i;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        drive(3'b111, 4'd3, 4'd4, 4'd5, 3'b000);

        // Reset state, even with requests asserted.
        #2;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rd_sel", 32'(bus.rd_sel), 32'd0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 3'b000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single request.
        bank[5] = 32'hDEAD_BEEF;
        drive(3'b001, 4'd5, 4'd0, 4'd0, 3'b000);
        step();
        drive(3'b000, 4'd5, 4'd0, 4'd0, 3'b001);
        #1;
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'b001);
        chk("single_rsp_data", bus.rsp_data, 32'hDEAD_BEEF);
        step();
        step();

        // Continuous requests, grant order and spacing.
        do_reset();
        glog.delete();
        gcyc.delete();
        drive(3'b111, 4'd1, 4'd2, 4'd3, 3'b111);
        for (int i = 0; i < 12; i++) step();
        chk("rr_grant_count", 32'(glog.size()), 32'd6);
        for (int i = 0; i < 6 && i < glog.size(); i++) begin
            chk("rr_order", 32'(glog[i]), 32'(i % 3));
            if (i > 0) chk("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd2);
        end

        // Backpressure for 5 cycles.
        drive(3'b111, 4'd9, 4'd10, 4'd11, 3'b000);
        step();
        for (int i = 0; i < 5; i++) step();
        bus.rsp_ready = 3'b111;
        step();
        step();
        step();

        // Pointer wrap.
        do_reset();
        drive(3'b100, 4'd0, 4'd0, 4'd6, 3'b111);
        step();
        chk("wrap_ptr_a", 32'(dut.rr_ptr), 32'd0);
        drive(3'b000, 4'd0, 4'd0, 4'd6, 3'b111);
        step();
        drive(3'b001, 4'd2, 4'd0, 4'd6, 3'b111);
        step();
        chk("wrap_ptr_b", 32'(dut.rr_ptr), 32'd1);
        drive(3'b000, 4'd2, 4'd0, 4'd6, 3'b111);
        step();

        // Same-cycle write to the granted register.
        bank[7] = 32'h0;
        drive(3'b010, 4'd0, 4'd7, 4'd0, 3'b000);
        bus.wr_en = 1'b1;
        bus.wr_addr = 4'd7;
        bus.wr_data = 32'h1234_5678;
        step();
        bus.wr_en = 1'b0;
        drive(3'b000, 4'd0, 4'd7, 4'd0, 3'b010);
        #1;
`ifdef REGBANK_BYPASS_EN
        chk("bypass_data", bus.rsp_data, 32'h1234_5678);
`else
        chk("bypass_data", bus.rsp_data, 32'h0);
`endif
        step();

        // Reset while a response is pending.
        drive(3'b100, 4'd0, 4'd0, 4'd8, 3'b000);
        step();
        drive(3'b000, 4'd0, 4'd0, 4'd8, 3'b000);
        #2;
        reset = 1'b1;
        #1;
        chk("hold_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("hold_rst_req_ready", 32'(bus.req_ready), 32'd0);
        m_pend = -1;
        m_ptr = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("hold_rst_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("hold_rst_state", 32'(dut.state), 32'(IDLE));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bus.req_valid = 3'($urandom_range(0, 7));
            bus.req_addr  = 12'($urandom);
            bus.rsp_ready = 3'($urandom_range(0, 7));
            bus.wr_en     = 1'($urandom_range(0, 1));
            bus.wr_addr   = 4'($urandom_range(0, 15));
            bus.wr_data   = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regbank_read_arbiter.md
Name: regbank_read_arbiter

Overview:
Shares the single 16:1 read port of the 16x32 register bank between N requesters (fetch/decode, execute, debug).
- Round-robin arbitration picks one requester per cycle and drives the bank read select.
- The selected 32-bit word is captured and returned one cycle later on a valid/ready response channel.
- Sits between the requesting pipeline stages and the register bank read mux.

Parameters:
NREQ, 3, number of requesters (2..8)
AW, 4, register address width (16 registers)
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester read request
req_addr  in  NREQ*AW  per-requester register index; requester i uses bits [i*AW +: AW]
req_ready  out  NREQ  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high
rd_sel  out  AW  select driven to the bank read mux
rd_data  in  DW  combinational mux output for rd_sel
rsp_valid  out  NREQ  one-hot; response pending for requester i
rsp_data  out  DW  captured register value
rsp_ready  in  NREQ  requester i accepts its response
wr_en  in  1  bank write strobe (used only with bypass)
wr_addr  in  AW  bank write index
wr_data  in  DW  bank write data

Behaviour:
- Reset values (asynchronous, active-high): rsp_valid=0, rsp_data=0, state=IDLE, rr_ptr=0, req_ready=0, rd_sel=0.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ.
  - req_ready is the combinational one-hot grant; rd_sel = req_addr of the granted requester.
  - With no valid requests: rd_sel holds its last value and req_ready=0.
- On accept:
  - rsp_data <= rd_data (bypass-adjusted when enabled).
  - rsp_valid <= onehot(i); rr_ptr <= (i+1) mod NREQ.
  - Next state HOLD.
- HOLD:
  - req_ready=0; rsp_valid and rsp_data are held stable.
  - When rsp_ready[i] is high for the pending i: rsp_valid <= 0 and the FSM returns to IDLE.
- Latency and throughput:
  - Grant to response is 1 cycle.
  - Peak throughput is one read every 2 cycles.
  - Zero-bubble back-to-back operation is not required.
- Responses are never dropped. Ready pulses on requesters without a pending response are ignored.
- Arbitration:
  - A requester that drops req_valid before grant loses nothing.
  - The pointer advances only on accept.
  - Fairness bound: a continuously requesting requester is granted within NREQ accepts.
- rr_ptr wraps from NREQ-1 to 0.
- Mid-operation reset clears a pending response immediately; the transaction is lost, and requesters re-issue.
- req_addr is fully decoded; every index 0..15 is valid, and no X or Z is ever driven on rd_sel.

Optional Feature:
Macro REGBANK_BYPASS_EN.
- Defined: in the accept cycle, if wr_en=1 and wr_addr equals the granted address, rsp_data captures wr_data instead of rd_data. This gives write-to-read forwarding for same-cycle writes.
- Undefined: wr_en, wr_addr and wr_data are unused and rsp_data always captures rd_data. This returns the pre-write value.

Decomposition:
- Shared package regbank_pkg holds:
  - REG_AW=4, REG_DW=32, REG_COUNT=16;
  - the state enum (IDLE, HOLD);
  - a reg_idx_t typedef.
- One sub-module, rr_arbiter:
  - parameterised NREQ;
  - inputs: request vector and pointer;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- The top holds the FSM, the pointer, the capture register and the bypass logic.

Test Plan:
- Reset, then a single request: req_valid=001 with addr 5 and bank r5=0xDEADBEEF. Expect req_ready=001 in the same cycle, then next cycle rsp_valid=001 and rsp_data=0xDEADBEEF. With rsp_ready=001, expect rsp_valid=0 one cycle later.
- All three request continuously with rsp_ready tied high. Expect grant order 0,1,2,0,1,2, with each grant 2 cycles apart.
- Backpressure: hold rsp_ready=0 for 5 cycles after a grant. Expect rsp_data stable, req_ready=000 throughout, and no new grant until the cycle after rsp_ready rises.
- Pointer wrap with NREQ=3: only requester 2, then only requester 0. Expect both granted, and rr_ptr 0 then 1.
- Bypass: grant addr 7 in the same cycle as wr_en=1, wr_addr=7, wr_data=0x12345678, with old r7=0x0. Expect rsp_data=0x12345678 with REGBANK_BYPASS_EN defined, and 0x0 without it.
- Assert reset during HOLD. Expect rsp_valid=0 immediately (asynchronous), and rr_ptr=0 and state IDLE after release.
